// File: rtl/fetch_unit_pkg.sv
// Shared constants and state encoding for the instruction-fetch sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fetch_unit_pkg;

    localparam int          FETCH_ADDR_W = 16;
    localparam int          FETCH_DATA_W = 16;
    // Amount added to the PC to move to the next instruction.
    localparam logic [7:0]  FETCH_STEP   = 8'd1;
    // Shown on Instr whenever nothing valid is being presented.
    localparam logic [15:0] FETCH_NOP    = 16'h0000;

    typedef enum logic [1:0] {
        S_START = 2'd0,
        S_FETCH = 2'd1,
        S_WAIT  = 2'd2,
        S_VALID = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Bundle of every non-clock signal between fetch_unit and its neighbours.
// Latency: n/a (wires only).
// Backpressure: InstrValid/InstrReady handshake towards decode.
// Groups: PC control (PC, PcIncrement, PcIn, PcImm, PcWriteEnable),
//         instruction memory (MemAddr, MemRead, MemData),
//         redirect (BranchValid, BranchTarget),
//         decode (InstrValid, Instr, InstrPC, InstrReady).
// master = fetch_unit side, slave = PC / memory / execute / decode side.
interface fetch_unit_if #(
    parameter int ADDR_W = fetch_unit_pkg::FETCH_ADDR_W,
    parameter int DATA_W = fetch_unit_pkg::FETCH_DATA_W
);
    logic [ADDR_W-1:0] PC;
    logic              PcIncrement;
    logic [7:0]        PcIn;
    logic [ADDR_W-1:0] PcImm;
    logic              PcWriteEnable;

    logic [ADDR_W-1:0] MemAddr;
    logic              MemRead;
    logic [DATA_W-1:0] MemData;

    logic              BranchValid;
    logic [ADDR_W-1:0] BranchTarget;

    logic              InstrValid;
    logic [DATA_W-1:0] Instr;
    logic [ADDR_W-1:0] InstrPC;
    logic              InstrReady;

    modport master (
        input  PC, MemData, BranchValid, BranchTarget, InstrReady,
        output PcIncrement, PcIn, PcImm, PcWriteEnable,
               MemAddr, MemRead, InstrValid, Instr, InstrPC
    );

    modport slave (
        output PC, MemData, BranchValid, BranchTarget, InstrReady,
        input  PcIncrement, PcIn, PcImm, PcWriteEnable,
               MemAddr, MemRead, InstrValid, Instr, InstrPC
    );

endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch sequencer: steers the PC, reads a 1-cycle-latency BRAM, presents one instr to decode.
// Latency: 2 cycles from S_FETCH to InstrValid; at best one instruction every 3 cycles.
// Backpressure: holds Instr/InstrPC in S_VALID until InstrReady; a branch redirect overrides everything.
// Ports: Clock, Reset (async, active-low), bus (fetch_unit_if.master: PC control,
//        memory read, branch redirect, decode handshake).
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int              ADDR_W    = FETCH_ADDR_W,
    parameter int              DATA_W    = FETCH_DATA_W,
    parameter logic [7:0]      STEP      = FETCH_STEP,
    parameter logic [DATA_W-1:0] NOP_INSTR = DATA_W'(FETCH_NOP)
) (
    input  logic         Clock,
    input  logic         Reset,
    fetch_unit_if.master bus
);

    fetch_state_t      state_q;
    fetch_state_t      state_d;

    logic              valid_q;
    logic [DATA_W-1:0] instr_q;
    logic [ADDR_W-1:0] instr_pc_q;

    // The cycle straight after reset ignores redirects: the PC already sits at
    // the reset vector, so there is nothing to correct.
    logic branch_take;
    assign branch_take = bus.BranchValid && (state_q != S_START);

    // State register
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_START;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_START: state_d = S_FETCH;
            S_FETCH: state_d = S_WAIT;
            S_WAIT:  state_d = S_VALID;
            S_VALID: if (bus.InstrReady) state_d = S_FETCH;
            default: state_d = S_START;
        endcase
        // A redirect restarts fetching from the target no matter where we were.
        if (branch_take) begin
            state_d = S_FETCH;
        end
    end

    // Output decode for the PC and memory controls.
    // The PC clears itself if neither increment nor write-enable is set, so
    // PcIncrement stays high permanently and PcIn=0 is used to hold.
    always_comb begin
        bus.PcIncrement   = 1'b1;
        bus.PcIn          = 8'd0;
        bus.PcWriteEnable = branch_take;
        bus.PcImm         = branch_take ? bus.BranchTarget : '0;
        bus.MemAddr       = bus.PC;
        bus.MemRead       = (state_q == S_FETCH);
        // Advance on the same edge that captures the returning data, unless a
        // redirect is discarding that data.
        if ((state_q == S_WAIT) && !branch_take) begin
            bus.PcIn = STEP;
        end
    end

    // Instruction register, its address and the valid flag.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            valid_q    <= 1'b0;
            instr_q    <= NOP_INSTR;
            instr_pc_q <= '0;
        end else if (branch_take) begin
            // Drops both a presented instruction and any read still in flight.
            valid_q <= 1'b0;
            instr_q <= NOP_INSTR;
        end else if (state_q == S_WAIT) begin
            valid_q    <= 1'b1;
            instr_q    <= bus.MemData;
            instr_pc_q <= bus.PC;
        end else if ((state_q == S_VALID) && bus.InstrReady) begin
            valid_q <= 1'b0;
            instr_q <= NOP_INSTR;
        end
    end

    assign bus.InstrValid = valid_q;
    assign bus.Instr      = instr_q;
    assign bus.InstrPC    = instr_pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit with a behavioural PC, a 64K-word BRAM and an in-order scoreboard.
// Latency: directed steps check exact cycle timing; the random phase checks only ordering and values.
// Backpressure: InstrReady and BranchValid are driven directly and randomised in the last phase.
module tb_fetch_unit;

    logic Clock;
    logic Reset;

    fetch_unit_if #(.ADDR_W(16), .DATA_W(16)) bus ();

    fetch_unit dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Program counter as the surrounding datapath implements it.
    always @(posedge Clock or negedge Reset) begin
        if (!Reset)                 bus.PC <= 16'h0000;
        else if (bus.PcWriteEnable) bus.PC <= bus.PcImm;
        else if (bus.PcIncrement)   bus.PC <= bus.PC + 16'(bus.PcIn);
        else                        bus.PC <= 16'h0000;
    end

    // Synchronous instruction memory, one cycle read latency.
    logic [15:0] mem [0:65535];
    always @(posedge Clock) begin
        if (bus.MemRead) bus.MemData <= mem[bus.MemAddr];
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: the stream decode sees is sequential addresses from
    // the last redirect (or 0 after reset), each carrying mem[address].
    int          k;          // cycle number since reset release, 0 = idle start cycle
    logic [15:0] exp_addr;
    int          accepted;
    logic        prev_hold;
    logic [15:0] prev_instr;
    logic [15:0] prev_ipc;

    task automatic release_reset();
        Reset     = 1'b1;
        k         = -1;
        exp_addr  = 16'h0000;
        prev_hold = 1'b0;
    endtask

    task automatic mon();
        logic redirect;
        @(negedge Clock);
        k++;
        if (Reset) begin
            redirect = bus.BranchValid && (k > 0);
            chk("pc_increment", bus.PcIncrement, 1);
            chk("mem_addr", bus.MemAddr, bus.PC);
            chk("pc_we", bus.PcWriteEnable, redirect);
            chk("pc_imm", bus.PcImm, redirect ? bus.BranchTarget : 16'h0000);
            if (!bus.InstrValid) begin
                chk("nop_when_idle", bus.Instr, 16'h0000);
            end else begin
                chk("sb_instr_pc", bus.InstrPC, exp_addr);
                chk("sb_instr", bus.Instr, mem[exp_addr]);
            end
            if (prev_hold) begin
                chk("hold_valid", bus.InstrValid, 1);
                chk("hold_instr", bus.Instr, prev_instr);
                chk("hold_pc", bus.InstrPC, prev_ipc);
            end
            prev_hold  = bus.InstrValid && !bus.InstrReady && !redirect;
            prev_instr = bus.Instr;
            prev_ipc   = bus.InstrPC;
            if (bus.InstrValid && bus.InstrReady) begin
                exp_addr = exp_addr + 16'd1;
                accepted++;
            end
            if (redirect) exp_addr = bus.BranchTarget;
        end
    endtask

    task automatic nxt();
        @(posedge Clock);
        #1;
    endtask

    task automatic step();
        nxt();
        mon();
    endtask

    task automatic upto(input int n);
        while (k < n) step();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_valid"}, bus.InstrValid, 0);
        chk({tag, "_instr"}, bus.Instr, 16'h0000);
        chk({tag, "_ipc"}, bus.InstrPC, 16'h0000);
        chk({tag, "_rd"}, bus.MemRead, 0);
        chk({tag, "_we"}, bus.PcWriteEnable, 0);
        chk({tag, "_inc"}, bus.PcIncrement, 1);
        chk({tag, "_pcin"}, bus.PcIn, 0);
        chk({tag, "_pc"}, bus.PC, 16'h0000);
    endtask

    initial begin
        Reset            = 1'b0;
        bus.InstrReady   = 1'b0;
        bus.BranchValid  = 1'b0;
        bus.BranchTarget = 16'h0000;
        k                = -1;
        exp_addr         = 16'h0000;
        accepted         = 0;
        prev_hold        = 1'b0;
        prev_instr       = 16'h0000;
        prev_ipc         = 16'h0000;
        for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
        mem[16'h0000] = 16'h1111;
        mem[16'h0001] = 16'h2222;
        mem[16'h0002] = 16'h3333;
        mem[16'h0040] = 16'h4040;
        mem[16'h0041] = 16'h4141;
        mem[16'h0100] = 16'h0101;
        mem[16'hFFFF] = 16'hABCD;

        repeat (3) @(posedge Clock);
        #1;
        chk_reset_vals("por");

        // Linear fetch with decode always ready.
        release_reset();
        bus.InstrReady = 1'b1;
        mon();
        for (int c = 0; c < 10; c++) begin
            if (c > 0) step();
            chk("lin_valid", bus.InstrValid, (k % 3 == 0) && (k > 0));
            chk("lin_pc", bus.PC, k / 3);
            chk("lin_rd", bus.MemRead, k % 3 == 1);
        end

        // Asynchronous reset in the middle of S_WAIT.
        upto(11);
        chk("pre_rst_pcin", bus.PcIn, 1);
        Reset = 1'b0;
        #1;
        chk_reset_vals("mid_wait_rst");
        repeat (2) @(posedge Clock);
        #1;

        // Decode stalls on the first instruction for five cycles.
        release_reset();
        bus.InstrReady = 1'b0;
        mon();
        upto(2);
        for (int c = 3; c <= 7; c++) begin
            step();
            chk("stall_valid", bus.InstrValid, 1);
            chk("stall_instr", bus.Instr, 16'h1111);
            chk("stall_ipc", bus.InstrPC, 16'h0000);
            chk("stall_pc", bus.PC, 16'h0001);
        end
        nxt();
        bus.InstrReady = 1'b1;
        mon();
        step();
        chk("after_stall_pc", bus.PC, 16'h0001);
        chk("after_stall_rd", bus.MemRead, 1);

        // Redirect while the read is in flight.
        nxt();
        bus.BranchValid  = 1'b1;
        bus.BranchTarget = 16'h0040;
        mon();
        chk("brw_pcin", bus.PcIn, 0);
        nxt();
        bus.BranchValid = 1'b0;
        mon();
        chk("brw_pc", bus.PC, 16'h0040);
        chk("brw_dropped", bus.InstrValid, 0);
        upto(13);
        chk("brw_valid", bus.InstrValid, 1);
        chk("brw_ipc", bus.InstrPC, 16'h0040);
        chk("brw_instr", bus.Instr, 16'h4040);

        // Redirect and acceptance in the same S_VALID cycle.
        upto(15);
        nxt();
        bus.BranchValid  = 1'b1;
        bus.BranchTarget = 16'h0100;
        mon();
        chk("brr_ipc", bus.InstrPC, 16'h0041);
        nxt();
        bus.BranchValid = 1'b0;
        mon();
        chk("brr_pc", bus.PC, 16'h0100);
        chk("brr_valid", bus.InstrValid, 0);

        // Redirect to the top of memory and wrap to zero.
        upto(18);
        nxt();
        bus.BranchValid  = 1'b1;
        bus.BranchTarget = 16'hFFFF;
        mon();
        chk("brr_instr", bus.Instr, 16'h0101);
        nxt();
        bus.BranchValid = 1'b0;
        mon();
        chk("wrap_pc_top", bus.PC, 16'hFFFF);
        upto(22);
        chk("wrap_instr", bus.Instr, 16'hABCD);
        chk("wrap_ipc", bus.InstrPC, 16'hFFFF);
        step();
        chk("wrap_pc_zero", bus.PC, 16'h0000);
        upto(25);
        chk("wrap_next_ipc", bus.InstrPC, 16'h0000);
        chk("wrap_next_instr", bus.Instr, 16'h1111);

        // Random decode backpressure and redirects.
        accepted = 0;
        for (int c = 0; c < 3000; c++) begin
            nxt();
            bus.InstrReady  = ($urandom_range(0, 3) != 0);
            bus.BranchValid = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 3) == 0)
                bus.BranchTarget = 16'(16'hFFF8 + 16'($urandom_range(0, 7)));
            else
                bus.BranchTarget = 16'($urandom);
            mon();
        end
        chk("rand_progress", accepted >= 200, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
